pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the 5-stage CPU: drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves memory-busy stalls, inserts load-use bubbles, and commits exceptions, external interrupts and ERET at the MEM stage. It also holds the exception PC, cause code and interrupt-enable state, and supplies the redirect PC to the fetch stage.

## Interface
Parameters:
- EXP_VECTOR, 30'h0000_0100, word address fetched after any exception or interrupt.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_  in  1  asynchronous, active-low reset.
- if_busy  in  1  fetch bus access not complete.
- mem_busy  in  1  data bus access not complete.
- ld_hazard  in  1  ID holds an instruction that needs the result of the load currently in EX.
- mem_pc  in  30  word PC of the instruction in MEM.
- mem_en  in  1  MEM slot holds a valid instruction.
- mem_exp_code  in  3  cause raised by the MEM instruction: 0 none, 1 EXT_INT (reserved for this block), 2 UNDEF_INSN, 3 OVERFLOW, 4 MISS_ALIGN, 5 TRAP, 6 PRV_VIO.
- mem_ctrl_op  in  2  0 NOP, 1 ERET, 2-3 treated as NOP.
- irq  in  1  level-sensitive external interrupt request.
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the corresponding pipeline register.
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  load NOP into the corresponding pipeline register.
- new_pc_en  out  1  redirect fetch this cycle.
- new_pc  out  30  redirect target.
- epc  out  30  saved exception PC.
- exp_cause  out  3  saved exception cause.
- int_en  out  1  interrupt enable.

## Operation
- Stall and flush are active-high. Flush takes effect only in cycles where the matching stall is low.
- stall = if_busy | mem_busy.
  - id_stall, ex_stall and mem_stall all equal stall.
  - if_stall = stall | ld_hazard.
- Effective cause:
  - If mem_en is 0, there is no event.
  - If mem_exp_code ≠ 0, the cause is mem_exp_code (internal exceptions have priority over interrupts).
  - Otherwise, if irq & int_en, the cause is 1 (EXT_INT).
  - Otherwise, if mem_ctrl_op = ERET, the event is ERET.
- Exception or interrupt event:
  - All four flushes = 1.
  - new_pc_en = 1, new_pc = EXP_VECTOR.
- ERET event:
  - All four flushes = 1.
  - new_pc_en = 1, new_pc = epc.
- No event: id_flush = ld_hazard (bubble into ID/EX). All other flushes = 0, new_pc_en = 0, new_pc = 0.
- Redirect outputs are gated by stall: while stall = 1, all flushes and new_pc_en are 0. The pending event stays in MEM, because MEM is frozen, and commits on the first cycle with stall = 0.
- State registers, updated only when stall = 0:
  - Exception/interrupt: epc ← mem_pc, exp_cause ← cause, saved_ie ← int_en, int_en ← 0.
  - ERET: int_en ← saved_ie. epc and exp_cause are unchanged.
- int_en is set to 1 one cycle after reset release. No software write path exists in this block.

## Timing
- Stall, flush and new_pc outputs are purely combinational from the current inputs and state, with zero latency.
- State registers change on the commit edge. A following event sees the updated values on the next cycle.
- Reset values:
  - epc = 0, exp_cause = 0, saved_ie = 0.
  - int_en = 0, then 1 on the first clock edge after reset_ deasserts.
  - All combinational outputs follow from these values.
- Reset asserted mid-stall or mid-event clears all state immediately. A pending event is lost; MEM is also reset.
- ld_hazard together with an event: the event wins, and all stages are flushed.
- ld_hazard together with stall: only stalls are asserted, with no bubble.
- A back-to-back exception, e.g. an exception on the vector instruction itself, overwrites epc. saved_ie then captures 0.

## Test plan
- Reset, then idle (mem_en = 0): all stalls and flushes 0 and int_en = 1 by cycle 2; epc = 0.
- ld_hazard = 1 for 1 cycle: if_stall = 1, id_flush = 1, all others 0. Next cycle all outputs are 0.
- mem_en = 1, mem_pc = 30'h40, mem_exp_code = 3, mem_busy = 1 for 3 cycles:
  - No flush for 3 cycles.
  - Cycle 4: all flushes, new_pc = 30'h100.
  - Next cycle: epc = 30'h40, exp_cause = 3, int_en = 0.
- irq = 1 with int_en = 1, mem_en = 1, mem_pc = 30'h55: commit with exp_cause = 1. Repeat irq while int_en = 0: no event.
- ERET after the previous case: new_pc = 30'h55, all flushes, int_en returns to 1.
- mem_exp_code = 2 with irq = 1: exp_cause = 2 (priority). Assert reset_ during a 2-cycle mem_busy with a pending exception: epc = 0 and no flush after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage CPU: stall/flush generation, exception and
// interrupt commit at MEM, ERET handling and the fetch redirect.
module pipe_ctrl #(
  parameter logic [29:0] EXP_VECTOR = 30'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic [29:0] mem_pc,
  input  logic        mem_en,
  input  logic [2:0]  mem_exp_code,
  input  logic [1:0]  mem_ctrl_op,
  input  logic        irq,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic        new_pc_en,
  output logic [29:0] new_pc,
  output logic [29:0] epc,
  output logic [2:0]  exp_cause,
  output logic        int_en
);

  localparam logic [2:0] CAUSE_EXT_INT = 3'd1;
  localparam logic [1:0] OP_ERET       = 2'd1;

  logic       stall;
  logic       exp_evt;
  logic       eret_evt;
  logic [2:0] cause;
  logic       saved_ie;
  logic       init_done;

  assign stall = if_busy | mem_busy;

  // Internal exceptions outrank the interrupt, which outranks ERET.
  always_comb begin
    exp_evt  = 1'b0;
    eret_evt = 1'b0;
    cause    = 3'd0;
    if (mem_en) begin
      if (mem_exp_code != 3'd0) begin
        exp_evt = 1'b1;
        cause   = mem_exp_code;
      end else if (irq && int_en) begin
        exp_evt = 1'b1;
        cause   = CAUSE_EXT_INT;
      end else if (mem_ctrl_op == OP_ERET) begin
        eret_evt = 1'b1;
      end
    end
  end

  // While stalled, MEM is frozen, so any pending event simply waits.
  always_comb begin
    if_stall  = stall | ld_hazard;
    id_stall  = stall;
    ex_stall  = stall;
    mem_stall = stall;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    new_pc_en = 1'b0;
    new_pc    = 30'd0;
    if (!stall) begin
      if (exp_evt || eret_evt) begin
        if_flush  = 1'b1;
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        mem_flush = 1'b1;
        new_pc_en = 1'b1;
        new_pc    = exp_evt ? EXP_VECTOR : epc;
      end else begin
        id_flush = ld_hazard;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      epc       <= 30'd0;
      exp_cause <= 3'd0;
      saved_ie  <= 1'b0;
      int_en    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (!init_done) int_en <= 1'b1;
      if (!stall) begin
        if (exp_evt) begin
          epc       <= mem_pc;
          exp_cause <= cause;
          saved_ie  <= int_en;
          int_en    <= 1'b0;
        end else if (eret_evt) begin
          int_en <= saved_ie;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of per-cycle vectors with expected
// outputs, followed by a hand-written reset-during-stall sequence.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset_;
  logic        if_busy, mem_busy, ld_hazard, mem_en, irq;
  logic [29:0] mem_pc;
  logic [2:0]  mem_exp_code;
  logic [1:0]  mem_ctrl_op;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        new_pc_en;
  logic [29:0] new_pc, epc;
  logic [2:0]  exp_cause;
  logic        int_en;

  int n_cmp = 0;
  int n_err = 0;

  logic [29:0] exp_q[$];

  typedef struct {
    logic        if_busy;
    logic        mem_busy;
    logic        ld_hazard;
    logic        mem_en;
    logic [29:0] mem_pc;
    logic [2:0]  code;
    logic [1:0]  op;
    logic        irq;
    logic [3:0]  e_stall;   // {if, id, ex, mem}
    logic [3:0]  e_flush;   // {if, id, ex, mem}
    logic        e_npc_en;
    logic [29:0] e_npc;
    logic [29:0] e_epc;
    logic [2:0]  e_cause;
    logic        e_int_en;
  } vec_t;

  vec_t vecs[24];

  pipe_ctrl #(.EXP_VECTOR(30'h0000_0100)) dut (
    .clk(clk), .reset_(reset_),
    .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_exp_code(mem_exp_code),
    .mem_ctrl_op(mem_ctrl_op), .irq(irq),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc_en(new_pc_en), .new_pc(new_pc), .epc(epc), .exp_cause(exp_cause),
    .int_en(int_en)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic ifb, input logic mb, input logic ldh, input logic en,
                              input logic [29:0] pc, input logic [2:0] code, input logic [1:0] op,
                              input logic irq_i, input logic [3:0] st, input logic [3:0] fl,
                              input logic npe, input logic [29:0] npc, input logic [29:0] e_epc,
                              input logic [2:0] ec, input logic ie);
    vec_t v;
    v.if_busy = ifb; v.mem_busy = mb; v.ld_hazard = ldh; v.mem_en = en;
    v.mem_pc = pc; v.code = code; v.op = op; v.irq = irq_i;
    v.e_stall = st; v.e_flush = fl; v.e_npc_en = npe; v.e_npc = npc;
    v.e_epc = e_epc; v.e_cause = ec; v.e_int_en = ie;
    return v;
  endfunction

  task automatic drive_idle();
    if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0;
    mem_pc = '0; mem_exp_code = '0; mem_ctrl_op = '0; irq = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    if_busy = v.if_busy; mem_busy = v.mem_busy; ld_hazard = v.ld_hazard;
    mem_en = v.mem_en; mem_pc = v.mem_pc; mem_exp_code = v.code;
    mem_ctrl_op = v.op; irq = v.irq;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".stall"}, {28'd0, if_stall, id_stall, ex_stall, mem_stall}, {28'd0, v.e_stall});
    check({tag, ".flush"}, {28'd0, if_flush, id_flush, ex_flush, mem_flush}, {28'd0, v.e_flush});
    check({tag, ".new_pc_en"}, {31'd0, new_pc_en}, {31'd0, v.e_npc_en});
    check({tag, ".new_pc"}, {2'd0, new_pc}, {2'd0, v.e_npc});
    check({tag, ".epc"}, {2'd0, epc}, {2'd0, v.e_epc});
    check({tag, ".exp_cause"}, {29'd0, exp_cause}, {29'd0, v.e_cause});
    check({tag, ".int_en"}, {31'd0, int_en}, {31'd0, v.e_int_en});
  endtask

  // Scoreboard: every observed redirect must match the next queued target.
  always @(negedge clk) begin
    #2;
    if (reset_ && new_pc_en) begin
      if (exp_q.size() == 0) begin
        check("redirect_unexpected", {2'd0, new_pc}, 32'hFFFF_FFFF);
      end else begin
        check("redirect_target", {2'd0, new_pc}, {2'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    //               ifb mb ldh en  pc        code op    irq  stall    flush    npe npc        epc        cause int_en
    vecs[0]  = mk(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,   30'h0,   3'd0, 1);
    vecs[1]  = mk(0, 0, 1, 0, 30'h0,   3'd0, 2'd0, 0, 4'b1000, 4'b0100, 0, 30'h0,   30'h0,   3'd0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,   30'h0,   3'd0, 1);
    vecs[3]  = mk(0, 1, 0, 1, 30'h40,  3'd3, 2'd0, 0, 4'b1111, 4'b0000, 0, 30'h0,   30'h0,   3'd0, 1);
    vecs[4]  = mk(0, 1, 0, 1, 30'h40,  3'd3, 2'd0, 0, 4'b1111, 4'b0000, 0, 30'h0,   30'h0,   3'd0, 1);
    vecs[5]  = mk(0, 1, 0, 1, 30'h40,  3'd3, 2'd0, 0, 4'b1111, 4'b0000, 0, 30'h0,   30'h0,   3'd0, 1);
    vecs[6]  = mk(0, 0, 0, 1, 30'h40,  3'd3, 2'd0, 0, 4'b0000, 4'b1111, 1, 30'h100, 30'h0,   3'd0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,   30'h40,  3'd3, 0);
    vecs[8]  = mk(0, 0, 0, 1, 30'h44,  3'd0, 2'd1, 0, 4'b0000, 4'b1111, 1, 30'h40,  30'h40,  3'd3, 0);
    vecs[9]  = mk(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,   30'h40,  3'd3, 1);
    vecs[10] = mk(0, 0, 0, 1, 30'h55,  3'd0, 2'd0, 1, 4'b0000, 4'b1111, 1, 30'h100, 30'h40,  3'd3, 1);
    vecs[11] = mk(0, 0, 0, 1, 30'h60,  3'd0, 2'd0, 1, 4'b0000, 4'b0000, 0, 30'h0,   30'h55,  3'd1, 0);
    vecs[12] = mk(0, 0, 0, 1, 30'h70,  3'd0, 2'd1, 0, 4'b0000, 4'b1111, 1, 30'h55,  30'h55,  3'd1, 0);
    vecs[13] = mk(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,   30'h55,  3'd1, 1);
    vecs[14] = mk(0, 0, 0, 1, 30'h80,  3'd2, 2'd0, 1, 4'b0000, 4'b1111, 1, 30'h100, 30'h55,  3'd1, 1);
    vecs[15] = mk(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,   30'h80,  3'd2, 0);
    vecs[16] = mk(0, 1, 1, 0, 30'h0,   3'd0, 2'd0, 0, 4'b1111, 4'b0000, 0, 30'h0,   30'h80,  3'd2, 0);
    vecs[17] = mk(0, 0, 1, 1, 30'h90,  3'd4, 2'd0, 0, 4'b1000, 4'b1111, 1, 30'h100, 30'h80,  3'd2, 0);
    vecs[18] = mk(0, 0, 0, 1, 30'h100, 3'd2, 2'd0, 0, 4'b0000, 4'b1111, 1, 30'h100, 30'h90,  3'd4, 0);
    vecs[19] = mk(0, 0, 0, 1, 30'h101, 3'd0, 2'd1, 0, 4'b0000, 4'b1111, 1, 30'h100, 30'h100, 3'd2, 0);
    vecs[20] = mk(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,   30'h100, 3'd2, 0);
    vecs[21] = mk(0, 0, 0, 0, 30'h20,  3'd5, 2'd1, 1, 4'b0000, 4'b0000, 0, 30'h0,   30'h100, 3'd2, 0);
    vecs[22] = mk(0, 0, 0, 1, 30'h24,  3'd0, 2'd2, 0, 4'b0000, 4'b0000, 0, 30'h0,   30'h100, 3'd2, 0);
    vecs[23] = mk(1, 0, 0, 1, 30'h28,  3'd5, 2'd0, 0, 4'b1111, 4'b0000, 0, 30'h0,   30'h100, 3'd2, 0);

    drive_idle();
    reset_ = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset.int_en", {31'd0, int_en}, 32'd0);
    check("reset.epc", {2'd0, epc}, 32'd0);
    check("reset.flush", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'd0);
    reset_ = 1'b1;
    #1;
    check("release.int_en", {31'd0, int_en}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      if (vecs[i].e_npc_en) exp_q.push_back(vecs[i].e_npc);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset arriving while an exception is held pending behind mem_busy.
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    mem_busy = 1; mem_en = 1; mem_pc = 30'h40; mem_exp_code = 3'd3;
    #1;
    check("rst_pend.flush", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'd0);
    @(negedge clk);
    reset_ = 1'b0;
    #1;
    check("rst_pend.int_en", {31'd0, int_en}, 32'd0);
    check("rst_pend.epc", {2'd0, epc}, 32'd0);
    check("rst_pend.cause", {29'd0, exp_cause}, 32'd0);
    @(negedge clk);
    drive_idle();
    reset_ = 1'b1;
    #1;
    check("rst_rel.flush", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'd0);
    check("rst_rel.new_pc_en", {31'd0, new_pc_en}, 32'd0);
    @(negedge clk);
    #1;
    check("rst_rel.int_en", {31'd0, int_en}, 32'd1);
    check("rst_rel.epc", {2'd0, epc}, 32'd0);

    @(negedge clk);
    #3;
    check("redirect_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
